// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU op classes
// and the control bundle carried in the ID/EX register.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       mem_write;
        logic       mem_read;
        logic       alu_src;
        logic       reg_dst;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_regfile.sv
// Two-read one-write register file with WB->ID write-through.
// Register 0 is hardwired to zero.
module id_regfile #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [REG_ADDR_W-1:0] raddr_a_i,
    input  logic [REG_ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0]     rdata_a_o,
    output logic [DATA_W-1:0]     rdata_b_o
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wr_en;

    assign wr_en = we_i && (waddr_i != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // A write landing this cycle is visible to readers in the same cycle.
    always_comb begin
        rdata_a_o = regs_q[raddr_a_i];
        if (raddr_a_i == '0) begin
            rdata_a_o = '0;
        end else if (wr_en && waddr_i == raddr_a_i) begin
            rdata_a_o = wdata_i;
        end
    end

    always_comb begin
        rdata_b_o = regs_q[raddr_b_i];
        if (raddr_b_i == '0) begin
            rdata_b_o = '0;
        end else if (wr_en && waddr_i == raddr_b_i) begin
            rdata_b_o = wdata_i;
        end
    end

endmodule

// File: rtl/id_stage_piped.sv
// MIPS decode stage: regfile, control decode, sign extension, load-use
// stall and flush handling, feeding the ID/EX pipeline register.
module id_stage_piped
    import id_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int IMM_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid_in,
    input  logic [31:0]           instruction,
    input  logic                  flush,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_write_reg,
    input  logic [DATA_W-1:0]     wb_write_data,
    output logic                  stall,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_branch,
    output logic                  ex_mem_write,
    output logic                  ex_mem_read,
    output logic                  ex_alu_src,
    output logic                  ex_reg_dst,
    output logic [1:0]            ex_alu_op,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [DATA_W-1:0]     ex_rs_data,
    output logic [DATA_W-1:0]     ex_rt_data,
    output logic [REG_ADDR_W-1:0] ex_rs,
    output logic [REG_ADDR_W-1:0] ex_rt,
    output logic [REG_ADDR_W-1:0] ex_rd
);

    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [DATA_W-1:0]     imm_ext;
    ctrl_t                 ctrl;
    logic                  uses_rt;
    logic                  hazard;
    logic                  load;

    logic                  valid_q,   valid_d;
    ctrl_t                 ctrl_q,    ctrl_d;
    logic [DATA_W-1:0]     imm_q,     imm_d;
    logic [DATA_W-1:0]     rs_data_q, rs_data_d;
    logic [DATA_W-1:0]     rt_data_q, rt_data_d;
    logic [REG_ADDR_W-1:0] rs_q,      rs_d;
    logic [REG_ADDR_W-1:0] rt_q,      rt_d;
    logic [REG_ADDR_W-1:0] rd_q,      rd_d;

    assign opcode  = instruction[31:26];
    assign rs      = instruction[21 +: REG_ADDR_W];
    assign rt      = instruction[16 +: REG_ADDR_W];
    assign rd      = instruction[11 +: REG_ADDR_W];
    assign imm_ext = {{(DATA_W-IMM_W){instruction[IMM_W-1]}},
                      instruction[IMM_W-1:0]};

    id_regfile #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) rf_main (
        .clk       (clk),
        .reset     (reset),
        .we_i      (wb_reg_write),
        .waddr_i   (wb_write_reg),
        .wdata_i   (wb_write_data),
        .raddr_a_i (rs),
        .raddr_b_i (rt),
        .rdata_a_o (rs_data),
        .rdata_b_o (rt_data)
    );

    always_comb begin
        ctrl    = CTRL_NOP;
        uses_rt = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
                uses_rt        = 1'b1;
            end
            OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                uses_rt        = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
                uses_rt     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Load in EX whose destination is a source of the instruction in ID.
    assign hazard = id_valid_in && valid_q && ctrl_q.mem_read &&
                    (rt_q != '0) &&
                    ((rt_q == rs) || (uses_rt && (rt_q == rt)));

    assign stall = hazard && !flush && !reset;
    assign load  = id_valid_in && !flush && !hazard;

    always_comb begin
        valid_d   = 1'b0;
        ctrl_d    = CTRL_NOP;
        imm_d     = '0;
        rs_data_d = '0;
        rt_data_d = '0;
        rs_d      = '0;
        rt_d      = '0;
        rd_d      = '0;
        if (load) begin
            valid_d   = 1'b1;
            ctrl_d    = ctrl;
            imm_d     = imm_ext;
            rs_data_d = rs_data;
            rt_data_d = rt_data;
            rs_d      = rs;
            rt_d      = rt;
            rd_d      = rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            ctrl_q    <= CTRL_NOP;
            imm_q     <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            imm_q     <= imm_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_branch     = ctrl_q.branch;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_reg_dst    = ctrl_q.reg_dst;
    assign ex_alu_op     = ctrl_q.alu_op;
    assign ex_imm        = imm_q;
    assign ex_rs_data    = rs_data_q;
    assign ex_rt_data    = rt_data_q;
    assign ex_rs         = rs_q;
    assign ex_rt         = rt_q;
    assign ex_rd         = rd_q;

endmodule

// File: tb/tb_id_stage_piped.sv
// Directed bench for id_stage_piped: reference model checked every cycle
// plus hand-computed expectations at the interesting points.
module tb_id_stage_piped;

    logic        clk;
    logic        reset;
    logic        id_valid_in;
    logic [31:0] instruction;
    logic        flush;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        stall;
    logic        ex_valid;
    logic        ex_reg_write, ex_mem_to_reg, ex_branch, ex_mem_write;
    logic        ex_mem_read, ex_alu_src, ex_reg_dst;
    logic [1:0]  ex_alu_op;
    logic [31:0] ex_imm, ex_rs_data, ex_rt_data;
    logic [4:0]  ex_rs, ex_rt, ex_rd;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    id_stage_piped dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid_in   (id_valid_in),
        .instruction   (instruction),
        .flush         (flush),
        .wb_reg_write  (wb_reg_write),
        .wb_write_reg  (wb_write_reg),
        .wb_write_data (wb_write_data),
        .stall         (stall),
        .ex_valid      (ex_valid),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_branch     (ex_branch),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_read   (ex_mem_read),
        .ex_alu_src    (ex_alu_src),
        .ex_reg_dst    (ex_reg_dst),
        .ex_alu_op     (ex_alu_op),
        .ex_imm        (ex_imm),
        .ex_rs_data    (ex_rs_data),
        .ex_rt_data    (ex_rt_data),
        .ex_rs         (ex_rs),
        .ex_rt         (ex_rt),
        .ex_rd         (ex_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // control vector: {uses_rt, rw, m2r, br, mw, mr, as, rdst, alu[1:0]}
    function automatic logic [9:0] m_dec(input logic [5:0] op);
        case (op)
            6'b000000: return 10'b1_1000001_10;
            6'b100011: return 10'b0_1100110_00;
            6'b101011: return 10'b1_0001010_00;
            6'b000100: return 10'b1_0010000_01;
            default:   return 10'b0_0000000_00;
        endcase
    endfunction

    logic [31:0] mreg [32];
    logic        e_valid;
    logic [8:0]  e_ctrl;
    logic [31:0] e_imm, e_rsd, e_rtd;
    logic [4:0]  e_rs, e_rt, e_rd;

    initial begin
        for (int i = 0; i < 32; i++) mreg[i] = 0;
        e_valid = 0; e_ctrl = 0; e_imm = 0; e_rsd = 0; e_rtd = 0;
        e_rs = 0; e_rt = 0; e_rd = 0;
    end

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
        if (wb_reg_write && wb_write_reg == idx) return wb_write_data;
        return mreg[idx];
    endfunction

    function automatic logic m_hazard();
        logic [9:0] d;
        logic [4:0] s, t;
        d = m_dec(instruction[31:26]);
        s = instruction[25:21];
        t = instruction[20:16];
        return id_valid_in && e_valid && e_ctrl[4] && e_rt != 0 &&
               (e_rt == s || (d[9] && e_rt == t));
    endfunction

    always @(posedge clk) begin
        logic [9:0] d;
        if (reset) begin
            for (int i = 0; i < 32; i++) mreg[i] = 0;
            e_valid = 0; e_ctrl = 0; e_imm = 0; e_rsd = 0; e_rtd = 0;
            e_rs = 0; e_rt = 0; e_rd = 0;
        end else begin
            if (id_valid_in && !flush && !m_hazard()) begin
                d       = m_dec(instruction[31:26]);
                e_valid = 1;
                e_ctrl  = d[8:0];
                e_rs    = instruction[25:21];
                e_rt    = instruction[20:16];
                e_rd    = instruction[15:11];
                e_imm   = {{16{instruction[15]}}, instruction[15:0]};
                e_rsd   = m_read(e_rs);
                e_rtd   = m_read(e_rt);
            end else begin
                e_valid = 0; e_ctrl = 0; e_imm = 0; e_rsd = 0; e_rtd = 0;
                e_rs = 0; e_rt = 0; e_rd = 0;
            end
            if (wb_reg_write && wb_write_reg != 0)
                mreg[wb_write_reg] = wb_write_data;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [9:0]  act_c;
        logic [95:0] act_d;
        logic [14:0] act_i;
        logic        exp_s;
        if (chk_en) begin
            act_c = {ex_valid, ex_reg_write, ex_mem_to_reg, ex_branch,
                     ex_mem_write, ex_mem_read, ex_alu_src, ex_reg_dst,
                     ex_alu_op};
            act_d = {ex_imm, ex_rs_data, ex_rt_data};
            act_i = {ex_rs, ex_rt, ex_rd};
            exp_s = m_hazard() && !flush && !reset;
            n_cmp += 4;
            if (act_c !== {e_valid, e_ctrl}) begin
                n_bad++;
                $display("FAIL model_ctrl t=%0t got %b want %b",
                         $time, act_c, {e_valid, e_ctrl});
            end
            if (act_d !== {e_imm, e_rsd, e_rtd}) begin
                n_bad++;
                $display("FAIL model_data t=%0t got %h want %h",
                         $time, act_d, {e_imm, e_rsd, e_rtd});
            end
            if (act_i !== {e_rs, e_rt, e_rd}) begin
                n_bad++;
                $display("FAIL model_idx t=%0t got %h want %h",
                         $time, act_i, {e_rs, e_rt, e_rd});
            end
            if (stall !== exp_s) begin
                n_bad++;
                $display("FAIL model_stall t=%0t got %b want %b",
                         $time, stall, exp_s);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] s,
                                          input logic [4:0] t,
                                          input logic [4:0] d);
        return {6'b000000, s, t, d, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op,
                                          input logic [4:0] s,
                                          input logic [4:0] t,
                                          input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    // Drive one cycle's inputs after the edge, then settle mid-cycle.
    task automatic cyc(input logic rst, input logic v,
                       input logic [31:0] ins, input logic fl,
                       input logic we, input logic [4:0] wr,
                       input logic [31:0] wd);
        @(posedge clk);
        #2;
        chk_en        = 1;
        reset         = rst;
        id_valid_in   = v;
        instruction   = ins;
        flush         = fl;
        wb_reg_write  = we;
        wb_write_reg  = wr;
        wb_write_data = wd;
        @(negedge clk);
        #1;
    endtask

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;

    logic [31:0] prog [8];

    initial begin
        reset = 1; id_valid_in = 0; instruction = 0; flush = 0;
        wb_reg_write = 0; wb_write_reg = 0; wb_write_data = 0;

        // reset
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("rst_ex_valid", {31'd0, ex_valid}, 0);
        check("rst_ctrl", {23'd0, ex_reg_write, ex_mem_to_reg, ex_branch,
              ex_mem_write, ex_mem_read, ex_alu_src, ex_reg_dst,
              ex_alu_op}, 0);
        check("rst_stall", {31'd0, stall}, 0);
        for (int i = 1; i < 32; i++)
            check("rst_rf", dut.rf_main.regs_q[i], 0);

        // write-through into add r9,r8,r8
        cyc(0, 1, rtype(8, 8, 9), 0, 1, 8, 32'h0000_00AA);
        cyc(0, 1, itype(LW, 0, 8, 16'd4), 0, 0, 0, 0);
        check("wt_rs_data", ex_rs_data, 32'hAA);
        check("wt_rt_data", ex_rt_data, 32'hAA);
        check("wt_alu_op", {30'd0, ex_alu_op}, 2);
        check("wt_rf_r8", dut.rf_main.regs_q[8], 32'hAA);

        // load-use via rs
        cyc(0, 1, rtype(8, 1, 9), 0, 0, 0, 0);
        check("lu_stall", {31'd0, stall}, 1);
        check("lu_lw_imm", ex_imm, 32'd4);
        cyc(0, 1, rtype(8, 1, 9), 0, 0, 0, 0);
        check("lu_bubble", {31'd0, ex_valid}, 0);
        check("lu_unstall", {31'd0, stall}, 0);
        cyc(0, 1, itype(LW, 0, 8, 16'd8), 0, 0, 0, 0);
        check("lu_add_in_ex", {ex_valid, ex_rs, ex_rt, ex_rd},
              {1'b1, 5'd8, 5'd1, 5'd9});

        // load-use via rt (sw), then lw r0 never stalls
        cyc(0, 1, itype(SW, 2, 8, 16'd0), 0, 0, 0, 0);
        check("sw_stall", {31'd0, stall}, 1);
        cyc(0, 1, itype(LW, 3, 0, 16'd0), 0, 0, 0, 0);
        cyc(0, 1, itype(SW, 2, 0, 16'd0), 0, 0, 0, 0);
        check("lwr0_mem_read", {31'd0, ex_mem_read}, 1);
        check("lwr0_stall", {31'd0, stall}, 0);

        // flush while a hazard is present
        cyc(0, 1, itype(LW, 0, 8, 16'd0), 0, 0, 0, 0);
        cyc(0, 1, rtype(8, 1, 9), 1, 0, 0, 0);
        check("fl_stall", {31'd0, stall}, 0);
        cyc(0, 1, itype(ADDI, 0, 10, 16'hFFFC), 0, 1, 0, 32'h1234);
        check("fl_bubble", {22'd0, ex_valid, ex_reg_write, ex_mem_to_reg,
              ex_branch, ex_mem_write, ex_mem_read, ex_alu_src,
              ex_reg_dst, ex_alu_op}, 0);

        // unsupported opcode, sign extension, r0 write ignored
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("addi_valid", {31'd0, ex_valid}, 1);
        check("addi_ctrl", {23'd0, ex_reg_write, ex_mem_to_reg, ex_branch,
              ex_mem_write, ex_mem_read, ex_alu_src, ex_reg_dst,
              ex_alu_op}, 0);
        check("addi_imm", ex_imm, 32'hFFFF_FFFC);
        check("addi_rs_data", ex_rs_data, 0);
        check("rf_r0", dut.rf_main.regs_q[0], 0);

        // reset mid-operation discards concurrent WB write
        cyc(1, 1, rtype(8, 8, 9), 0, 1, 5, 32'h55);
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("mrst_valid", {31'd0, ex_valid}, 0);
        check("mrst_r5", dut.rf_main.regs_q[5], 0);
        check("mrst_r8", dut.rf_main.regs_q[8], 0);

        // short mixed stream, model-checked
        prog[0] = rtype(1, 2, 3);
        prog[1] = itype(BEQ, 3, 4, 16'h8000);
        prog[2] = itype(LW, 1, 5, 16'h0010);
        prog[3] = rtype(5, 5, 6);
        prog[4] = itype(SW, 6, 5, 16'hFFF0);
        prog[5] = itype(LW, 2, 7, 16'h7FFF);
        prog[6] = itype(BEQ, 1, 7, 16'h0001);
        prog[7] = rtype(7, 3, 2);
        for (int i = 0; i < 8; i++)
            cyc(0, 1, prog[i], 0, 1, 5'(i + 1), 32'h1000 + 32'(i * 3));
        cyc(0, 1, prog[7], 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
